rf_writeback: RTL and testbench

Writeback unit that owns the write side of the integer register file. It accepts results from the execute path (EX) and the load/store path (LS) over valid/ready handshakes and arbitrates them round-robin. It drives the single register-file write port through one register stage and maintains a per-register pending scoreboard, which the issue stage uses for hazard checks. The unit also suppresses all writes to x0, because the register file itself does not guard x0.

---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_scoreboard.sv | 58 +++++
 rtl/rf_writeback.sv | 86 ++++++++
 tb/tb_rf_writeback.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared constants and types for the register-file writeback unit.
package wb_pkg;

    localparam int XLEN_D = 64;
    localparam int AW_D   = 5;
    localparam int NREG_D = 32;

    typedef enum logic {
        SRC_EX = 1'b0,
        SRC_LS = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Purpose: per-register pending scoreboard with source lookups and orphan-writeback detection.
// Latency: set/clear take effect at the next edge; lookups and set_rdy are combinational.
// Backpressure: set_rdy is low while the requested destination is still pending.
module wb_scoreboard import wb_pkg::*; #(
    parameter int NREG = NREG_D,
    parameter int AW   = AW_D
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_vld,
    input  logic [AW-1:0] set_rd,
    output logic          set_rdy,
    input  logic          clr_vld,
    input  logic [AW-1:0] clr_rd,
    input  logic          wb_vld,
    input  logic [AW-1:0] wb_rd,
    input  logic [AW-1:0] chk_rs1,
    input  logic [AW-1:0] chk_rs2,
    input  logic [AW-1:0] chk_rs3,
    output logic          chk_busy1,
    output logic          chk_busy2,
    output logic          chk_busy3,
    output logic          err
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    assign set_rdy   = (set_rd == '0) | ~busy_q[set_rd];
    assign chk_busy1 = busy_q[chk_rs1];
    assign chk_busy2 = busy_q[chk_rs2];
    assign chk_busy3 = busy_q[chk_rs3];

    // Set and clear target different indices by construction, so order here is immaterial.
    always_comb begin
        busy_d = busy_q;
        if (set_vld && set_rdy && set_rd != '0) begin
            busy_d[set_rd] = 1'b1;
        end
        if (clr_vld) begin
            busy_d[clr_rd] = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            err    <= 1'b0;
        end else begin
            busy_q <= busy_d;
            if (wb_vld && wb_rd != '0 && !busy_q[wb_rd]) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_writeback.sv
// Purpose: round-robin EX/LS result arbiter driving the register-file write port, plus hazard scoreboard.
// Latency: one cycle from accepted handshake to rf_we/rf_a/rf_d; one result per cycle sustained.
// Backpressure: only arbitration loss holds off a producer; the register file always accepts.
module rf_writeback import wb_pkg::*; #(
    parameter int XLEN = XLEN_D,
    parameter int NREG = NREG_D,
    parameter int AW   = AW_D
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ready,
    input  logic            ex_valid,
    input  logic [AW-1:0]   ex_rd,
    input  logic [XLEN-1:0] ex_data,
    output logic            ex_ready,
    input  logic            ls_valid,
    input  logic [AW-1:0]   ls_rd,
    input  logic [XLEN-1:0] ls_data,
    output logic            ls_ready,
    output logic            rf_we,
    output logic [AW-1:0]   rf_a,
    output logic [XLEN-1:0] rf_d,
    input  logic [AW-1:0]   chk_rs1,
    input  logic [AW-1:0]   chk_rs2,
    input  logic [AW-1:0]   chk_rs3,
    output logic            chk_busy1,
    output logic            chk_busy2,
    output logic            chk_busy3,
    output logic            err
);

    wb_src_e         prio;
    logic            acc_vld;
    logic [AW-1:0]   acc_rd;
    logic [XLEN-1:0] acc_dat;

    assign ex_ready = ex_valid & (~ls_valid | (prio == SRC_EX));
    assign ls_ready = ls_valid & (~ex_valid | (prio == SRC_LS));
    assign acc_vld  = ex_ready | ls_ready;
    assign acc_rd   = ex_ready ? ex_rd   : ls_rd;
    assign acc_dat  = ex_ready ? ex_data : ls_data;

    // rd=0 results complete the handshake but never reach the write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio  <= SRC_EX;
            rf_we <= 1'b0;
            rf_a  <= '0;
            rf_d  <= '0;
        end else begin
            if (ex_valid && ls_valid) begin
                prio <= (prio == SRC_EX) ? SRC_LS : SRC_EX;
            end
            rf_we <= acc_vld & (acc_rd != '0);
            if (acc_vld) begin
                rf_a <= acc_rd;
                rf_d <= acc_dat;
            end
        end
    end

    wb_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_vld   (issue_valid),
        .set_rd    (issue_rd),
        .set_rdy   (issue_ready),
        .clr_vld   (rf_we),
        .clr_rd    (rf_a),
        .wb_vld    (acc_vld),
        .wb_rd     (acc_rd),
        .chk_rs1   (chk_rs1),
        .chk_rs2   (chk_rs2),
        .chk_rs3   (chk_rs3),
        .chk_busy1 (chk_busy1),
        .chk_busy2 (chk_busy2),
        .chk_busy3 (chk_busy3),
        .err       (err)
    );

endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback with hand-computed expectations.
module tb_rf_writeback;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_ready;
    logic        ex_valid = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic [63:0] ex_data = '0;
    logic        ex_ready;
    logic        ls_valid = 1'b0;
    logic [4:0]  ls_rd = '0;
    logic [63:0] ls_data = '0;
    logic        ls_ready;
    logic        rf_we;
    logic [4:0]  rf_a;
    logic [63:0] rf_d;
    logic [4:0]  chk_rs1 = '0;
    logic [4:0]  chk_rs2 = '0;
    logic [4:0]  chk_rs3 = '0;
    logic        chk_busy1, chk_busy2, chk_busy3;
    logic        err;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rf_writeback dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .ex_valid    (ex_valid),
        .ex_rd       (ex_rd),
        .ex_data     (ex_data),
        .ex_ready    (ex_ready),
        .ls_valid    (ls_valid),
        .ls_rd       (ls_rd),
        .ls_data     (ls_data),
        .ls_ready    (ls_ready),
        .rf_we       (rf_we),
        .rf_a        (rf_a),
        .rf_d        (rf_d),
        .chk_rs1     (chk_rs1),
        .chk_rs2     (chk_rs2),
        .chk_rs3     (chk_rs3),
        .chk_busy1   (chk_busy1),
        .chk_busy2   (chk_busy2),
        .chk_busy3   (chk_busy3),
        .err         (err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        #12;
        check_eq("rst_rf_we", rf_we, 0);
        check_eq("rst_rf_a", rf_a, 0);
        check_eq("rst_rf_d", rf_d, 0);
        check_eq("rst_err", err, 0);
        chk_rs1 = 5'd5; chk_rs2 = 5'd1; chk_rs3 = 5'd31;
        #1;
        check_eq("rst_busy", {chk_busy1, chk_busy2, chk_busy3}, 0);
        rst_n = 1'b1;
        tick();

        // single EX writeback of rd=5
        issue_valid = 1'b1; issue_rd = 5'd5;
        #1 check_eq("t1_issue_rdy", issue_ready, 1);
        tick();
        issue_valid = 1'b0;
        check_eq("t1_busy_set", chk_busy1, 1);
        ex_valid = 1'b1; ex_rd = 5'd5; ex_data = 64'hDEAD;
        #1 check_eq("t1_ex_ready", ex_ready, 1);
        tick();
        ex_valid = 1'b0;
        check_eq("t1_rf_we", rf_we, 1);
        check_eq("t1_rf_a", rf_a, 5);
        check_eq("t1_rf_d", rf_d, 64'hDEAD);
        check_eq("t1_busy_n1", chk_busy1, 1);
        tick();
        check_eq("t1_busy_clr", chk_busy1, 0);
        check_eq("t1_rf_we_off", rf_we, 0);
        check_eq("t1_err", err, 0);

        // both sources valid: EX,LS,EX,LS
        for (int r = 1; r <= 4; r++) begin
            issue_valid = 1'b1; issue_rd = 5'(r);
            tick();
        end
        issue_valid = 1'b0;
        ex_valid = 1'b1; ex_rd = 5'd1; ex_data = 64'h101;
        ls_valid = 1'b1; ls_rd = 5'd2; ls_data = 64'h202;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq($sformatf("t2_ex_rdy%0d", i), ex_ready, (i % 2 == 0) ? 1 : 0);
            check_eq($sformatf("t2_ls_rdy%0d", i), ls_ready, (i % 2 == 1) ? 1 : 0);
            tick();
            check_eq($sformatf("t2_we%0d", i), rf_we, 1);
            check_eq($sformatf("t2_a%0d", i), rf_a, 64'(i + 1));
            check_eq($sformatf("t2_d%0d", i), rf_d, (i % 2 == 0) ? 64'h101 * (i + 1) : 64'h202 + 64'h202 * (i / 2));
            if (i == 0) begin ex_rd = 5'd3; ex_data = 64'h303; end
            if (i == 1) begin ls_rd = 5'd4; ls_data = 64'h404; end
            if (i == 2) ex_valid = 1'b0;
            if (i == 3) ls_valid = 1'b0;
        end
        chk_rs1 = 5'd1; chk_rs2 = 5'd3; chk_rs3 = 5'd4;
        #1 check_eq("t2_busy_after", {chk_busy1, chk_busy2, chk_busy3}, 3'b001);
        tick();
        check_eq("t2_we_end", rf_we, 0);
        check_eq("t2_busy4", chk_busy3, 0);
        check_eq("t2_err", err, 0);

        // rd=0 result
        ex_valid = 1'b1; ex_rd = 5'd0; ex_data = 64'h1234; chk_rs1 = 5'd0;
        #1 check_eq("t3_ex_ready", ex_ready, 1);
        check_eq("t3_busy0a", chk_busy1, 0);
        tick();
        ex_valid = 1'b0;
        check_eq("t3_rf_we", rf_we, 0);
        check_eq("t3_err", err, 0);
        check_eq("t3_busy0b", chk_busy1, 0);

        // issue blocked while rd=7 pending
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        check_eq("t4_blocked0", issue_ready, 0);
        ex_valid = 1'b1; ex_rd = 5'd7; ex_data = 64'h77;
        #1 check_eq("t4_ex_ready", ex_ready, 1);
        check_eq("t4_blocked1", issue_ready, 0);
        tick();
        ex_valid = 1'b0;
        check_eq("t4_blocked2", issue_ready, 0);
        check_eq("t4_rf_a", rf_a, 7);
        tick();
        check_eq("t4_unblocked", issue_ready, 1);
        tick();
        issue_valid = 1'b0;
        check_eq("t4_reissued", issue_ready, 0);

        // orphan LS writeback to rd=9
        ls_valid = 1'b1; ls_rd = 5'd9; ls_data = 64'h99;
        #1 check_eq("t5_ls_ready", ls_ready, 1);
        check_eq("t5_err_pre", err, 0);
        tick();
        ls_valid = 1'b0;
        check_eq("t5_err_set", err, 1);
        check_eq("t5_rf_we", rf_we, 1);
        check_eq("t5_rf_a", rf_a, 9);
        check_eq("t5_rf_d", rf_d, 64'h99);
        tick(); tick();
        check_eq("t5_err_sticky", err, 1);

        // async reset with a write in flight and rd 7,10,11 busy
        for (int r = 10; r <= 11; r++) begin
            issue_valid = 1'b1; issue_rd = 5'(r);
            tick();
        end
        issue_valid = 1'b0;
        ex_valid = 1'b1; ex_rd = 5'd10; ex_data = 64'hA0;
        tick();
        ex_valid = 1'b0;
        chk_rs1 = 5'd7; chk_rs2 = 5'd10; chk_rs3 = 5'd11;
        #1 check_eq("t6_we_pre", rf_we, 1);
        check_eq("t6_busy_pre", {chk_busy1, chk_busy2, chk_busy3}, 3'b111);
        rst_n = 1'b0;
        #1 check_eq("t6_we_async", rf_we, 0);
        check_eq("t6_err_clr", err, 0);
        #10 rst_n = 1'b1;
        tick();
        check_eq("t6_busy_post", {chk_busy1, chk_busy2, chk_busy3}, 3'b000);
        check_eq("t6_we_post", rf_we, 0);
        ex_valid = 1'b1; ex_rd = 5'd0;
        ls_valid = 1'b1; ls_rd = 5'd0;
        #1 check_eq("t6_prio_ex", ex_ready, 1);
        check_eq("t6_prio_ls", ls_ready, 0);
        tick();
        ex_valid = 1'b0; ls_valid = 1'b0;
        check_eq("t6_err_end", err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
